// File: rtl/constraint_sample_collector.sv
// -----------------------------------------------------------------------------
// constraint_sample_collector
//
// Drives pseudo-random candidates into an external combinational constraint
// checker, samples its verdict and buffers accepted candidates in a small FIFO
// that is presented as a valid/ready stream. A run stops after target_count
// accepts or after MAX_ATTEMPTS checked candidates, whichever comes first.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             pulse, begins a run from IDLE or DONE
//   seed              LFSR seed, captured when a start is accepted
//   target_count      number of accepts that finishes the run
//   cand/cand_valid   candidate to the checker; valid while under check
//   x                 checker verdict, combinational from cand
//   sample_data       FIFO head (registered)
//   sample_valid      FIFO non-empty
//   sample_ready      consumer takes the head when valid & ready
//   busy              run in progress (FILL or CHECK)
//   done / timeout    run finished / finished by attempt budget
//   attempts          candidates checked this run (saturating)
//   accepted          candidates pushed this run
// -----------------------------------------------------------------------------
module constraint_sample_collector #(
   parameter int CAND_W       = 185,
   parameter int CNT_W        = 16,
   parameter int MAX_ATTEMPTS = 65535,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [31:0]       seed,
   input  logic [CNT_W-1:0]  target_count,
   output logic [CAND_W-1:0] cand,
   output logic              cand_valid,
   input  logic              x,
   output logic [CAND_W-1:0] sample_data,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [31:0]       attempts,
   output logic [CNT_W-1:0]  accepted
);

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
   localparam int BEATS  = (CAND_W + 31) / 32;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [31:0]       MAX_ATT   = 32'(MAX_ATTEMPTS);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_CHECK, S_DONE} state_t;

   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
   endfunction

   // ---------------------------------------------------------------- state
   state_t             state_q,    state_d;
   logic [CAND_W-1:0]  cand_q,     cand_d;
   logic [31:0]        lfsr_q,     lfsr_d;
   logic [BEAT_W-1:0]  beat_q,     beat_d;
   logic [31:0]        attempts_q, attempts_d;
   logic [CNT_W-1:0]   accepted_q, accepted_d;
   logic [CNT_W-1:0]   target_q,   target_d;
   logic               done_q,     done_d;
   logic               timeout_q,  timeout_d;

   // ---------------------------------------------------------------- fifo
   logic [CAND_W-1:0]  mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
   logic [PTR_W:0]     count_q,    count_d;
   logic [CAND_W-1:0]  head_q,     head_d;

   logic               push, pop, fifo_full;
   logic [PTR_W-1:0]   rd_nx;
   logic [31:0]        att_nx;
   logic [CNT_W-1:0]   acc_nx;

   assign fifo_full = (count_q == FULL_CNT);
   assign pop       = (count_q != '0) && sample_ready;
   assign rd_nx     = rd_ptr_q + PTR_W'(1);
   // attempts never wraps
   assign att_nx    = (attempts_q == '1) ? attempts_q : attempts_q + 32'd1;
   assign acc_nx    = accepted_q + CNT_W'(x);

   // --------------------------------------------------- control next state
   always_comb begin
      state_d    = state_q;
      cand_d     = cand_q;
      lfsr_d     = lfsr_q;
      beat_d     = beat_q;
      attempts_d = attempts_q;
      accepted_d = accepted_q;
      target_d   = target_q;
      done_d     = done_q;
      timeout_d  = timeout_q;
      push       = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               // an all-zero Galois LFSR would lock up, so seed 0 maps to 1
               lfsr_d     = (seed == 32'h0) ? 32'h1 : seed;
               attempts_d = '0;
               accepted_d = '0;
               timeout_d  = 1'b0;
               target_d   = target_count;
               beat_d     = '0;
               if (target_count == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_FILL;
                  done_d  = 1'b0;
               end
            end
         end

         S_FILL: begin
            cand_d = {cand_q[CAND_W-33:0], lfsr_q};
            lfsr_d = lfsr_step(lfsr_q);
            if (beat_q == LAST_BEAT) begin
               beat_d  = '0;
               state_d = S_CHECK;
            end else begin
               beat_d  = beat_q + BEAT_W'(1);
            end
         end

         S_CHECK: begin
            // an accepted candidate waits here for FIFO space; a pop in the
            // same cycle does not free the slot until the next edge
            if (!(x && fifo_full)) begin
               attempts_d = att_nx;
               accepted_d = acc_nx;
               push       = x;
               // completion takes priority over the attempt budget
               if (acc_nx == target_q) begin
                  state_d   = S_DONE;
                  done_d    = 1'b1;
                  timeout_d = 1'b0;
               end else if (att_nx == MAX_ATT) begin
                  state_d   = S_DONE;
                  done_d    = 1'b1;
                  timeout_d = 1'b1;
               end else begin
                  state_d   = S_FILL;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------ fifo next state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      head_d   = head_q;

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_nx;

      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W + 1)'(1);
         2'b01:   count_d = count_q - (PTR_W + 1)'(1);
         default: count_d = count_q;
      endcase

      // head register shadows mem[rd_ptr] while non-empty and keeps its last
      // value once the FIFO drains
      if (push && ((count_q == '0) || (pop && count_q == (PTR_W + 1)'(1)))) begin
         head_d = cand_q;
      end else if (pop && count_q > (PTR_W + 1)'(1)) begin
         head_d = mem_q[rd_nx];
      end
   end

   // ------------------------------------------------------------ registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cand_q     <= '0;
         lfsr_q     <= '0;
         beat_q     <= '0;
         attempts_q <= '0;
         accepted_q <= '0;
         target_q   <= '0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         head_q     <= '0;
      end else begin
         state_q    <= state_d;
         cand_q     <= cand_d;
         lfsr_q     <= lfsr_d;
         beat_q     <= beat_d;
         attempts_q <= attempts_d;
         accepted_q <= accepted_d;
         target_q   <= target_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         head_q     <= head_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= cand_q;
      end
   end

   // -------------------------------------------------------------- outputs
   assign cand         = cand_q;
   assign cand_valid   = (state_q == S_CHECK);
   assign busy         = (state_q == S_FILL) || (state_q == S_CHECK);
   assign done         = done_q;
   assign timeout      = timeout_q;
   assign attempts     = attempts_q;
   assign accepted     = accepted_q;
   assign sample_valid = (count_q != '0);
   assign sample_data  = head_q;

endmodule

// File: tb/tb_constraint_sample_collector.sv
module tb_constraint_sample_collector;
   localparam int CW = 185;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // main instance
   logic          start = 1'b0;
   logic [31:0]   seed = '0;
   logic [15:0]   target = '0;
   logic [CW-1:0] cand, sdata;
   logic          cand_valid, x, svalid, busy, done, timeout;
   logic          sready = 1'b0;
   logic [31:0]   attempts;
   logic [15:0]   accepted;
   logic [1:0]    xmode = 2'd0;   // 0: x=1, 1: x=0, 2: low nibble == A

   assign x = (xmode == 2'd0) ? 1'b1 :
              (xmode == 2'd1) ? 1'b0 : (cand[3:0] == 4'hA);

   // small-budget instance with a rejecting checker
   logic          start2 = 1'b0;
   logic [CW-1:0] cand2, sdata2;
   logic          cand_valid2, svalid2, busy2, done2, timeout2;
   logic [31:0]   attempts2;
   logic [15:0]   accepted2;

   constraint_sample_collector dut (
      .clk(clk), .rst(rst), .start(start), .seed(seed), .target_count(target),
      .cand(cand), .cand_valid(cand_valid), .x(x), .sample_data(sdata),
      .sample_valid(svalid), .sample_ready(sready), .busy(busy), .done(done),
      .timeout(timeout), .attempts(attempts), .accepted(accepted));

   constraint_sample_collector #(.MAX_ATTEMPTS(5)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .seed(32'h1), .target_count(16'd2),
      .cand(cand2), .cand_valid(cand_valid2), .x(1'b0), .sample_data(sdata2),
      .sample_valid(svalid2), .sample_ready(1'b1), .busy(busy2), .done(done2),
      .timeout(timeout2), .attempts(attempts2), .accepted(accepted2));

   int compared = 0;
   int mism = 0;
   int rej = 0;
   logic [CW-1:0] got[$];
   logic [CW-1:0] mc[$];

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      compared++;
      assert (obs === exp) else begin
         mism++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] stp(input logic [31:0] l);
      return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   // candidates produced by successive attempts from a seed
   task automatic model_gen(input logic [31:0] sd, input int n);
      logic [31:0] l;
      logic [CW-1:0] c;
      mc.delete();
      l = (sd == 32'h0) ? 32'h1 : sd;
      c = '0;
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < 6; b++) begin
            c = {c[CW-33:0], l};
            l = stp(l);
         end
         mc.push_back(c);
      end
   endtask

   // attempts needed for `need` candidates with low nibble A
   task automatic model_nib(input logic [31:0] sd, input int need, input int cap, output int att);
      logic [31:0] l;
      logic [CW-1:0] c;
      mc.delete();
      att = 0;
      l = (sd == 32'h0) ? 32'h1 : sd;
      c = '0;
      while (mc.size() < need && att < cap) begin
         for (int b = 0; b < 6; b++) begin
            c = {c[CW-33:0], l};
            l = stp(l);
         end
         att++;
         if (c[3:0] == 4'hA) mc.push_back(c);
      end
   endtask

   task automatic step_rec();
      if (svalid && sready) got.push_back(sdata);
      if (cand_valid && !x) rej++;
      tick();
   endtask

   task automatic pulse(input logic [31:0] s, input logic [15:0] t);
      seed   = s;
      target = t;
      start  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   task automatic run_done(input int maxc, output int cyc, output int first);
      cyc = 0;
      first = -1;
      while (!done && cyc < maxc) begin
         if (cand_valid && first < 0) first = cyc;
         step_rec();
         cyc++;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 6; i++) step_rec();
   endtask

   task automatic chk_samples(input string tag, input int n);
      chk({tag, "_count"}, got.size(), n);
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_%0d", tag, i), (i < got.size()) ? got[i] : 'x, mc[i]);
   endtask

   initial begin
      int cyc, first, c2, seen, att;
      logic [CW-1:0] held;

      // ---- reset state
      tick(); tick();
      chk("rst_cand", cand, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_svalid", svalid, 0);
      chk("rst_sdata", sdata, 0);
      chk("rst_attempts", attempts, 0);
      chk("rst_cvalid", cand_valid, 0);
      rst = 1'b0;
      tick();

      // ---- x=1, seed 1, target 3
      xmode = 2'd0; sready = 1'b1; got.delete();
      pulse(32'h1, 16'd3);
      chk("t1_busy", busy, 1);
      run_done(500, cyc, first);
      chk("t1_done", done, 1);
      chk("t1_cycles", cyc, 21);
      chk("t1_first_cvalid", first, 6);
      chk("t1_attempts", attempts, 3);
      chk("t1_accepted", accepted, 3);
      chk("t1_timeout", timeout, 0);
      drain();
      model_gen(32'h1, 3);
      chk_samples("t1_sample", 3);

      // ---- x=0, budget 5, target 2
      start2 = 1'b1; tick(); start2 = 1'b0;
      c2 = 0; seen = 0;
      while (!done2 && c2 < 200) begin
         if (svalid2) seen = 1;
         tick();
         c2++;
      end
      chk("t2_done", done2, 1);
      chk("t2_cycles", c2, 35);
      chk("t2_timeout", timeout2, 1);
      chk("t2_attempts", attempts2, 5);
      chk("t2_accepted", accepted2, 0);
      chk("t2_svalid_seen", seen, 0);

      // ---- x=1, target 8, consumer stalled, then drains
      sready = 1'b0; got.delete();
      model_gen(32'h1234_5678, 8);
      pulse(32'h1234_5678, 16'd8);
      for (int i = 0; i < 40; i++) step_rec();
      chk("t3_stall_attempts", attempts, 4);
      chk("t3_stall_accepted", accepted, 4);
      chk("t3_stall_cvalid", cand_valid, 1);
      chk("t3_stall_cand", cand, mc[4]);
      chk("t3_head", sdata, mc[0]);
      held = cand;
      for (int i = 0; i < 10; i++) step_rec();
      chk("t3_held_cand", cand, held);
      chk("t3_held_attempts", attempts, 4);
      sready = 1'b1;
      run_done(300, cyc, first);
      chk("t3_done", done, 1);
      chk("t3_attempts", attempts, 8);
      chk("t3_timeout", timeout, 0);
      drain();
      chk_samples("t3_sample", 8);

      // ---- seed 0 behaves as seed 1; target 0 finishes immediately
      got.delete();
      pulse(32'h0, 16'd1);
      run_done(100, cyc, first);
      chk("t4_cycles", cyc, 7);
      drain();
      model_gen(32'h1, 1);
      chk_samples("t4_seed0", 1);
      pulse(32'h5555_0000, 16'd0);
      chk("t4_t0_done", done, 1);
      chk("t4_t0_attempts", attempts, 0);
      chk("t4_t0_accepted", accepted, 0);
      chk("t4_t0_busy", busy, 0);
      tick();
      chk("t4_t0_busy2", busy, 0);

      // ---- checker accepts only low nibble A
      xmode = 2'd2; got.delete(); rej = 0;
      model_nib(32'h0000_ACE1, 2, 2500, att);
      chk("t5_model_found", mc.size(), 2);
      pulse(32'h0000_ACE1, 16'd2);
      run_done(2500 * 7 + 50, cyc, first);
      chk("t5_done", done, 1);
      chk("t5_attempts", attempts, att);
      chk("t5_accepted", accepted, 2);
      chk("t5_acc_plus_rej", accepted + rej, attempts);
      drain();
      chk_samples("t5_sample", 2);
      for (int i = 0; i < 2; i++)
         chk($sformatf("t5_nibble_%0d", i), (i < got.size()) ? got[i][3:0] : 4'hx, 4'hA);

      // ---- async reset during 2nd attempt fill, then rerun
      xmode = 2'd0; got.delete();
      pulse(32'h1, 16'd5);
      for (int i = 0; i < 9; i++) step_rec();
      chk("t6_pre_attempts", attempts, 1);
      chk("t6_pre_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("t6_cand", cand, 0);
      chk("t6_busy", busy, 0);
      chk("t6_cvalid", cand_valid, 0);
      chk("t6_done", done, 0);
      chk("t6_timeout", timeout, 0);
      chk("t6_attempts", attempts, 0);
      chk("t6_accepted", accepted, 0);
      chk("t6_svalid", svalid, 0);
      chk("t6_sdata", sdata, 0);
      tick();
      rst = 1'b0;
      tick();
      got.delete();
      pulse(32'hDEAD_BEEF, 16'd1);
      run_done(100, cyc, first);
      chk("t6_rerun_done", done, 1);
      chk("t6_rerun_attempts", attempts, 1);
      drain();
      model_gen(32'hDEAD_BEEF, 1);
      chk_samples("t6_rerun", 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end
endmodule

// File: doc/constraint_sample_collector.md
Name: constraint_sample_collector

Overview:
- Sequential driver/collector wrapped around a generated combinational constraint checker (185-bit candidate in, single-bit `x` out).
- Generates pseudo-random candidate vectors from an LFSR and drives them to the checker.
- Samples the checker verdict and buffers accepted candidates in a small FIFO, exposed as a valid/ready stream.
- Stops after a target number of accepts or an attempt budget; provides attempt/accept statistics for the sampler lab.

Parameters:
- CAND_W, 185, candidate width = sum of checker input widths, packed var_9 (MSBs) … var_0 (LSBs)
- CNT_W, 16, width of target/accept counters
- MAX_ATTEMPTS, 65535, attempt budget before timeout (≥1)
- FIFO_DEPTH, 4, accepted-sample buffer depth (power of 2, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a run when in IDLE or DONE
- seed  in  32  LFSR seed, captured on accepted start
- target_count  in  CNT_W  accepts required to finish
- cand  out  CAND_W  candidate driven to checker inputs
- cand_valid  out  1  high while cand is stable and under check
- x  in  1  checker verdict (combinational from cand)
- sample_data  out  CAND_W  FIFO head
- sample_valid  out  1  FIFO non-empty
- sample_ready  in  1  consumer accepts head when valid&ready
- busy  out  1  state is FILL or CHECK
- done  out  1  run finished
- timeout  out  1  run ended by attempt budget
- attempts  out  32  candidates checked this run
- accepted  out  CNT_W  candidates pushed this run

Behaviour:
- Reset, asynchronous, clears everything:
  - state = IDLE
  - cand, lfsr, attempts, accepted = 0
  - done, timeout, busy, cand_valid, sample_valid = 0
  - FIFO emptied
- LFSR: 32-bit Galois, taps 0x80200003.
  - Each step: lfsr = (lfsr >> 1) ^ (lfsr[0] ? 0x80200003 : 0).
  - Seed 0 is loaded as 0x00000001.
- IDLE/DONE, on start:
  - load lfsr from seed; clear attempts, accepted, done, timeout.
  - If target_count == 0: go to DONE next cycle with done = 1, no attempts made.
  - Otherwise go to FILL.
  - start is ignored in FILL and CHECK.
- FILL, 6 cycles (ceil(185/32)):
  - each cycle, cand <= {cand[CAND_W-33:0], lfsr}, then step the LFSR.
  - Beat counter runs 0..5; after beat 5 go to CHECK.
- CHECK:
  - cand_valid = 1; cand held constant.
  - x is sampled on the clock edge that ends CHECK.
  - If x = 1 and the FIFO is full: stall in CHECK (cand held, attempts not incremented) until space exists.
  - Otherwise, at that edge:
    - attempts += 1
    - if x = 1: push cand and accepted += 1.
- Exit from CHECK, evaluated on the post-update counts:
  - accepted == target_count → DONE, done = 1, timeout = 0.
  - else attempts == MAX_ATTEMPTS → DONE, done = 1, timeout = 1.
  - else → FILL.
  - If both hold on the same edge, completion wins (timeout = 0).
- DONE:
  - done held until the next accepted start.
  - FIFO keeps draining; FIFO is not flushed by start.
- FIFO:
  - Pop when sample_valid & sample_ready.
  - Push and pop in the same cycle is legal when not full. When full, the push is blocked by the stall rule, even if a pop happens that cycle; the push proceeds the following cycle.
  - sample_data = head, registered; valid one cycle after push into an empty FIFO.
  - sample_data is undefined-free: holds the last value (or 0 after reset) when empty.
- Latency:
  - start → first cand_valid: 7 cycles (1 load + 6 fill).
  - Per attempt: 7 cycles minimum (6 FILL + 1 CHECK).
- Counters: attempts saturates at 2^32−1; never wraps.
- Reset asserted mid-run (any state) aborts immediately; no partial push.

Test Plan:
- Stub x = 1 constant, seed 0x1, target_count 3, sample_ready = 1 → 3 samples out, attempts = 3, accepted = 3, done = 1, timeout = 0 at cycle 1+3×7. First sample equals the model-computed 6-beat LFSR fill from 0x00000001.
- Stub x = 0, MAX_ATTEMPTS = 5, target 2 → done = 1, timeout = 1, attempts = 5, accepted = 0, no sample_valid ever.
- x = 1, target 8, sample_ready = 0 → 4 pushes, then CHECK stalls with cand constant and attempts = 4. Raising sample_ready drains; the run completes with 8 samples in order.
- seed 0 vs seed 1 → identical candidate streams; target_count 0 → done next cycle, attempts = 0.
- Stub x = (cand[3:0] == 4'hA), target 2 → every emitted sample has low nibble 0xA; accepted + rejects = attempts.
- Assert rst during FILL of the 2nd attempt → all outputs 0 within the same cycle (async); a later start reruns from the new seed.
